// File: rtl/i2c_reg_ctrl.sv
// I2C-side register file: pointer/data write sequencing, auto-increment reads,
// and a host port. The optional write interrupt is built when I2C_REG_IRQ_EN is defined.
module i2c_reg_ctrl #(
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i2c_done,
    input  logic       i2c_rw,
    input  logic [7:0] i2c_wdata,
    output logic [7:0] i2c_rdata,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       host_ack,
    output logic       irq,
    input  logic       irq_clr
);
    typedef enum logic {ST_PTR, ST_DATA} state_t;

    state_t      state;
    logic [7:0]  regfile [16];
    logic [3:0]  ptr;
    logic [15:0] idle_cnt;
    logic        done_s1, done_s2, done_s3;
    logic        read_ev, write_ev, i2c_commit, host_accept, idle_hit;

    // done_s1/done_s2 synchronise; done_s3 is the previous synchronised value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_s3 <= 1'b0;
        end else begin
            done_s1 <= i2c_done;
            done_s2 <= done_s1;
            done_s3 <= done_s2;
        end
    end

    assign read_ev     = done_s2 & ~done_s3 & i2c_rw;
    assign write_ev    = ~done_s2 & done_s3 & ~i2c_rw;
    assign i2c_commit  = write_ev && (state == ST_DATA);
    assign idle_hit    = (idle_cnt == 16'(IDLE_TIMEOUT));
    // A host write loses to a coincident I2C commit and retries; reads always proceed.
    assign host_accept = host_req && !(host_we && i2c_commit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (read_ev || write_ev) begin
            idle_cnt <= '0;
        end else if (!idle_hit) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_PTR;
            ptr   <= 4'd0;
        end else if (read_ev) begin
            state <= ST_PTR;
            ptr   <= ptr + 4'd1;
        end else if (write_ev) begin
            if (state == ST_PTR) begin
                state <= ST_DATA;
                ptr   <= i2c_wdata[3:0];
            end else begin
                ptr   <= ptr + 4'd1;
            end
        end else if (state == ST_DATA && idle_hit) begin
            state <= ST_PTR;
        end
    end

    // I2C and host writes never land in the same cycle: host_accept excludes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) regfile[i] <= 8'h00;
        end else if (i2c_commit) begin
            regfile[ptr] <= i2c_wdata;
        end else if (host_accept && host_we) begin
            regfile[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i2c_rdata <= 8'h00;
        end else begin
            i2c_rdata <= regfile[ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_ack   <= 1'b0;
            host_rdata <= 8'h00;
        end else begin
            host_ack <= host_accept;
            if (host_accept) host_rdata <= regfile[host_addr];
        end
    end

`ifdef I2C_REG_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else if (i2c_commit) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq = 1'b0;
`endif

endmodule

// File: doc/i2c_reg_ctrl.md
I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

Interface
REQ-001 SHALL have parameter IDLE_TIMEOUT, default 1024, meaning clk cycles without an I2C byte event before the write-sequence state returns to ST_PTR (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i2c_done  input  1  byte-complete flag from the I2C slave, asynchronous to clk.
REQ-005 SHALL have port i2c_rw  input  1  slave transfer direction, 1 = master read; quasi-static.
REQ-006 SHALL have port i2c_wdata  input  8  byte written by the master (slave data_out); quasi-static.
REQ-007 SHALL have port i2c_rdata  output  8  byte returned to the master (slave data_in).
REQ-008 SHALL have port host_req  input  1  host access request, held until host_ack.
REQ-009 SHALL have port host_we  input  1  host write (1) or read (0).
REQ-010 SHALL have port host_addr  input  4  host register index.
REQ-011 SHALL have port host_wdata  input  8  host write data.
REQ-012 SHALL have port host_rdata  output  8  host read data, valid while host_ack is high.
REQ-013 SHALL have port host_ack  output  1  one-cycle acknowledge of an accepted host access.
REQ-014 SHALL have port irq  output  1  I2C-write-occurred interrupt, level.
REQ-015 SHALL have port irq_clr  input  1  host clear of irq.

Function
REQ-016 SHALL hold a register file of 16 x 8 bits and a 4-bit pointer ptr.
REQ-017 SHALL synchronise i2c_done through two flops, then a third flop for edge detection, giving 3-cycle detect latency.
REQ-018 SHALL treat a synchronised rising edge with i2c_rw=1 as a read event: ptr <= ptr+1 (wraps 15->0), state <= ST_PTR.
REQ-019 SHALL treat a synchronised falling edge with i2c_rw=0 as a write event, sampling i2c_wdata that cycle; the rising edge with i2c_rw=0 and the falling edge with i2c_rw=1 are ignored.
REQ-020 SHALL, on a write event in ST_PTR, load ptr <= i2c_wdata[3:0] (bits 7:4 ignored) and go to ST_DATA.
REQ-021 SHALL, on a write event in ST_DATA, write regfile[ptr] <= i2c_wdata and ptr <= ptr+1 (wraps 15->0); state stays ST_DATA.
REQ-022 SHALL count clk cycles since the last read or write event and, upon reaching IDLE_TIMEOUT in ST_DATA, go to ST_PTR; counter saturates, restarts on any event.
REQ-023 SHALL drive i2c_rdata as a registered copy of regfile[ptr], updated every cycle (one-cycle lag after any ptr or regfile change).
REQ-024 SHALL accept a host request on a cycle with host_req=1 unless host_we=1 and an I2C register write (REQ-021) commits that same cycle; I2C wins, host retries next cycle.
REQ-025 SHALL assert host_ack for exactly one cycle after the accepting edge; a host write updates regfile[host_addr] at that edge; host_rdata is regfile[host_addr] as of that edge.
REQ-026 SHALL treat host_req still high during the host_ack cycle as a new request.
REQ-027 SHALL, on a host write and I2C write to the same register in one cycle, keep the I2C value (host not accepted).
REQ-028 SHALL have host reads never blocked by I2C activity.

Reset
REQ-029 SHALL, while reset_n=0, force: regfile all 0x00, ptr=0, state ST_PTR, timeout counter 0, synchroniser flops 0, i2c_rdata=0x00, host_rdata=0x00, host_ack=0, irq=0.
REQ-030 SHALL, on reset assertion mid-transaction, discard any pending event; first event after release is handled from ST_PTR.

Configuration
REQ-031 SHALL, with I2C_REG_IRQ_EN defined, set irq on every REQ-021 commit and clear it on irq_clr=1; set wins over simultaneous clear.
REQ-032 SHALL, without I2C_REG_IRQ_EN, tie irq to 0 and ignore irq_clr; all other behaviour identical.

Verification
REQ-033 SHALL cover: I2C writes 0x03,0xAA,0xBB -> regfile[3]=0xAA, regfile[4]=0xBB, ptr=5, irq=1 (macro defined).
REQ-034 SHALL cover: I2C writes 0x0F,0x11,0x22 -> regfile[15]=0x11, regfile[0]=0x22, ptr=1 (wrap).
REQ-035 SHALL cover: pointer 0x03 written, then two read events -> i2c_rdata shows 0xAA, then 0xBB, then regfile[5]; state ST_PTR.
REQ-036 SHALL cover: host write 0x55 to reg 4 coincident with an I2C commit to reg 4 of 0x77 -> regfile[4]=0x77, host_ack delayed one cycle, then regfile[4]=0x55.
REQ-037 SHALL cover: ST_DATA idle for IDLE_TIMEOUT cycles, then I2C write 0x09 -> ptr=9, no regfile change; reset_n pulsed mid-byte -> all REQ-029 values.
